// File: rtl/calculator_pkg.sv
// Shared widths and controller state encoding for the calculator datapath.
package calculator_pkg;

  localparam int DATA_W        = 32;
  localparam int MEM_WORD_SIZE = 64;
  localparam int ADDR_W        = 8;

  typedef enum logic [2:0] {
    S_IDLE,
    S_READ,
    S_LOAD,
    S_CAPTURE,
    S_WRITE,
    S_DONE
  } ctrl_state_t;

endpackage

// File: rtl/calc_controller.sv
// Sequences SRAM reads of operand-pair words into the adder and writes packed
// 64-bit results back, two sums per result word.
module calc_controller
  import calculator_pkg::*;
(
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     start_i,
  input  logic [ADDR_W-1:0]        read_start_addr_i,
  input  logic [ADDR_W-1:0]        read_end_addr_i,
  input  logic [ADDR_W-1:0]        write_start_addr_i,
  input  logic [ADDR_W-1:0]        write_end_addr_i,
  input  logic [MEM_WORD_SIZE-1:0] rdata_i,
  output logic                     read_o,
  output logic [ADDR_W-1:0]        read_addr_o,
  output logic                     write_o,
  output logic [ADDR_W-1:0]        write_addr_o,
  output logic [DATA_W-1:0]        op_a_o,
  output logic [DATA_W-1:0]        op_b_o,
  output logic                     loc_sel_o,
  output logic                     busy_o,
  output logic                     done_o
);

  ctrl_state_t        state_q, state_d;
  logic [ADDR_W-1:0]  r_ptr_q, r_ptr_d;
  logic [ADDR_W-1:0]  w_ptr_q, w_ptr_d;
  logic [DATA_W-1:0]  op_a_q, op_a_d;
  logic [DATA_W-1:0]  op_b_q, op_b_d;
  logic               loc_sel_q, loc_sel_d;

  logic r_last, w_last;

  assign r_last = (r_ptr_q == read_end_addr_i);
  assign w_last = (w_ptr_q == write_end_addr_i);

  always_comb begin
    state_d   = state_q;
    r_ptr_d   = r_ptr_q;
    w_ptr_d   = w_ptr_q;
    op_a_d    = op_a_q;
    op_b_d    = op_b_q;
    loc_sel_d = loc_sel_q;

    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          r_ptr_d   = read_start_addr_i;
          w_ptr_d   = write_start_addr_i;
          loc_sel_d = 1'b0;
          state_d   = S_READ;
        end
      end
      S_READ: state_d = S_LOAD;
      S_LOAD: begin
        op_a_d  = rdata_i[DATA_W-1:0];
        op_b_d  = rdata_i[MEM_WORD_SIZE-1:DATA_W];
        state_d = S_CAPTURE;
      end
      // The result buffer latches the sum at the end of this cycle, so the
      // half select may only move once we have left it.
      S_CAPTURE: begin
        if (loc_sel_q || r_last) begin
          state_d = S_WRITE;
        end else begin
          loc_sel_d = 1'b1;
          r_ptr_d   = r_ptr_q + 1'b1;
          state_d   = S_READ;
        end
      end
      S_WRITE: begin
        if (r_last || w_last) begin
          state_d = S_DONE;
        end else begin
          r_ptr_d   = r_ptr_q + 1'b1;
          w_ptr_d   = w_ptr_q + 1'b1;
          loc_sel_d = 1'b0;
          state_d   = S_READ;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= S_IDLE;
      r_ptr_q   <= '0;
      w_ptr_q   <= '0;
      op_a_q    <= '0;
      op_b_q    <= '0;
      loc_sel_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      r_ptr_q   <= r_ptr_d;
      w_ptr_q   <= w_ptr_d;
      op_a_q    <= op_a_d;
      op_b_q    <= op_b_d;
      loc_sel_q <= loc_sel_d;
    end
  end

  // Strobes decode straight from the state register so a reset drops them at once.
  assign read_o       = (state_q == S_READ);
  assign write_o      = (state_q == S_WRITE);
  assign read_addr_o  = read_o  ? r_ptr_q : '0;
  assign write_addr_o = write_o ? w_ptr_q : '0;
  assign op_a_o       = op_a_q;
  assign op_b_o       = op_b_q;
  assign loc_sel_o    = loc_sel_q;
  assign busy_o       = (state_q != S_IDLE);
  assign done_o       = (state_q == S_DONE);

endmodule
